// File: rtl/mac_result_unpacker.sv
// Splits packed two-lane MAC results into a serial lane stream with packet sequence tags.
// A small FIFO decouples the packed source from the one-lane-per-cycle output register.
module mac_result_unpacker #(
    parameter int LANE_W     = 48,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_ce,
    input  logic                s_valid,
    input  logic [2*LANE_W-1:0] s_data,
    output logic                s_ready,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [LANE_W-1:0]   m_data,
    output logic                m_lane,
    output logic [7:0]          m_seq,
    output logic                m_last
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_L0,
        ST_L1
    } state_t;

    logic [2*LANE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;

    state_t              state_q, state_d;
    logic                m_valid_q, m_valid_d;
    logic [LANE_W-1:0]   m_data_q, m_data_d;
    logic                m_lane_q, m_lane_d;
    logic [7:0]          m_seq_q, m_seq_d;
    logic [7:0]          seq_cnt_q, seq_cnt_d;

    logic                push, pop, load;
    logic [2*LANE_W-1:0] head;

    // s_ready looks only at the registered count, so a same-cycle pop never opens a full FIFO.
    assign s_ready = ap_ce && (count_q < DEPTH_C);
    assign push    = s_valid && s_ready;
    assign load    = ap_ce && (!m_valid_q || m_ready);
    assign head    = mem_q[rd_ptr_q];
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_lane_d  = m_lane_q;
        m_seq_d   = m_seq_q;
        seq_cnt_d = seq_cnt_q;
        pop       = 1'b0;
        if (load) begin
            case (state_q)
                ST_L0: begin
                    // Head entry stays buffered until its second lane is loaded.
                    m_data_d = head[LANE_W-1:0];
                    m_lane_d = 1'b1;
                    pop      = 1'b1;
                    state_d  = ST_L1;
                end
                default: begin
                    if (count_q != '0) begin
                        m_valid_d = 1'b1;
                        m_data_d  = head[2*LANE_W-1:LANE_W];
                        m_lane_d  = 1'b0;
                        m_seq_d   = seq_cnt_q;
                        seq_cnt_d = seq_cnt_q + 8'd1;
                        state_d   = ST_L0;
                    end else begin
                        m_valid_d = 1'b0;
                        state_d   = ST_EMPTY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q   <= ST_EMPTY;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_lane_q  <= 1'b0;
            m_seq_q   <= '0;
            seq_cnt_q <= '0;
        end else if (ap_ce) begin
            state_q   <= state_d;
            count_q   <= count_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_lane_q  <= m_lane_d;
            m_seq_q   <= m_seq_d;
            seq_cnt_q <= seq_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage needs no reset: entries are only read while count_q marks them valid.
    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_lane  = m_lane_q;
    assign m_seq   = m_seq_q;
    assign m_last  = m_lane_q;

endmodule

// File: tb/tb_mac_result_unpacker.sv
// Self-checking bench for mac_result_unpacker: packet-queue reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_mac_result_unpacker;

    localparam int LW    = 48;
    localparam int DEPTH = 2;
    typedef logic [2*LW-1:0] v_t;

    logic          ap_clk   = 1'b0;
    logic          ap_rst_n = 1'b1;
    logic          ap_ce    = 1'b0;
    logic          s_valid  = 1'b0;
    logic          m_ready  = 1'b0;
    logic [2*LW-1:0] s_data = '0;
    wire           s_ready, m_valid, m_lane, m_last;
    wire [LW-1:0]  m_data;
    wire [7:0]     m_seq;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model: buffered packets plus the currently presented lane.
    v_t            mq[$];
    logic          e_valid = 1'b0;
    logic [LW-1:0] e_data  = '0;
    logic          e_lane  = 1'b0;
    logic [7:0]    e_seq   = '0;
    logic [7:0]    e_cnt   = '0;

    always #5 ap_clk = ~ap_clk;

    mac_result_unpacker #(.LANE_W(LW), .FIFO_DEPTH(DEPTH)) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .ap_ce   (ap_ce),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_lane  (m_lane),
        .m_seq   (m_seq),
        .m_last  (m_last)
    );

    task automatic chk(input string name, input v_t got, input v_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return ap_ce && (mq.size() < DEPTH);
    endfunction

    function automatic v_t rnd();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        mq.delete();
        e_valid = 1'b0;
        e_data  = '0;
        e_lane  = 1'b0;
        e_seq   = '0;
        e_cnt   = '0;
    endtask

    task automatic model_edge();
        logic acc, ld;
        v_t   h;
        acc = ap_ce && s_valid && (mq.size() < DEPTH);
        ld  = ap_ce && (!e_valid || m_ready);
        if (ld) begin
            if (e_valid && !e_lane) begin
                h = mq[0];
                e_data = h[LW-1:0];
                e_lane = 1'b1;
                void'(mq.pop_front());
            end else if (mq.size() > 0) begin
                h = mq[0];
                e_data  = h[2*LW-1:LW];
                e_lane  = 1'b0;
                e_seq   = e_cnt;
                e_cnt   = e_cnt + 8'd1;
                e_valid = 1'b1;
            end else begin
                e_valid = 1'b0;
            end
        end
        if (acc) mq.push_back(s_data);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        if (ap_rst_n) model_edge();
        #1;
    endtask

    task automatic do_reset();
        #2;
        ap_rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_m_valid", v_t'(m_valid), v_t'(1'b0));
        chk("rst_m_data", v_t'(m_data), v_t'(0));
        chk("rst_m_seq", v_t'(m_seq), v_t'(0));
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    always @(negedge ap_clk) begin
        if (chk_en) begin
            chk("s_ready", v_t'(s_ready), v_t'(exp_ready()));
            chk("m_valid", v_t'(m_valid), v_t'(e_valid));
            chk("m_data", v_t'(m_data), v_t'(e_data));
            chk("m_lane", v_t'(m_lane), v_t'(e_lane));
            chk("m_last", v_t'(m_last), v_t'(e_lane));
            chk("m_seq", v_t'(m_seq), v_t'(e_seq));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          acc;
        v_t            pa, pb, pc, pd, p0, p1, p2;
        logic [LW-1:0] gd [6];
        logic [7:0]    gs [6];
        logic [LW-1:0] xd [6];
        logic [7:0]    xs [6];
        int            got, sent, lanes, first, last;
        logic [7:0]    last_seq;

        ap_ce   = 1'b1;
        m_ready = 1'b1;
        tick();
        do_reset();
        chk_en = 1'b1;

        // Basic single packet
        s_data  = {48'h0000_0000_0001, 48'hFFFF_FFFF_FFFE};
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("basic_accept_edge_valid", v_t'(m_valid), v_t'(1'b0));
        tick();
        chk("basic_l0_valid", v_t'(m_valid), v_t'(1'b1));
        chk("basic_l0_data", v_t'(m_data), v_t'(48'h1));
        chk("basic_l0_lane", v_t'(m_lane), v_t'(1'b0));
        chk("basic_l0_seq", v_t'(m_seq), v_t'(8'd0));
        tick();
        chk("basic_l1_data", v_t'(m_data), v_t'(48'hFFFF_FFFF_FFFE));
        chk("basic_l1_lane", v_t'(m_lane), v_t'(1'b1));
        chk("basic_l1_last", v_t'(m_last), v_t'(1'b1));
        tick();
        chk("basic_drain_valid", v_t'(m_valid), v_t'(1'b0));

        // Backpressure with three packets
        do_reset();
        m_ready = 1'b0;
        pa = rnd(); pb = rnd(); pc = rnd();
        s_valid = 1'b1;
        s_data  = pa;
        tick();
        s_data = pb;
        tick();
        chk("bp_s_ready_full", v_t'(s_ready), v_t'(1'b0));
        s_data = pc;
        for (int i = 0; i < 3; i++) begin
            chk("bp_frozen_valid", v_t'(m_valid), v_t'(1'b1));
            chk("bp_frozen_data", v_t'(m_data), v_t'(pa[2*LW-1:LW]));
            chk("bp_frozen_lane", v_t'(m_lane), v_t'(1'b0));
            tick();
        end
        m_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 6; c++) begin
            if (m_valid && m_ready) begin
                gd[got] = m_data;
                gs[got] = m_seq;
                got++;
            end
            acc = s_valid && s_ready;
            tick();
            if (acc) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        chk("bp_lane_count", v_t'(got), v_t'(6));
        xd = '{pa[2*LW-1:LW], pa[LW-1:0], pb[2*LW-1:LW], pb[LW-1:0], pc[2*LW-1:LW], pc[LW-1:0]};
        xs = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
        for (int i = 0; i < got; i++) begin
            chk("bp_order_data", v_t'(gd[i]), v_t'(xd[i]));
            chk("bp_order_seq", v_t'(gs[i]), v_t'(xs[i]));
        end

        // Streaming 300 packets
        do_reset();
        chk("post_rst_s_ready", v_t'(s_ready), v_t'(1'b1));
        m_ready = 1'b1;
        sent = 0; lanes = 0; first = -1; last = -1; last_seq = '0;
        s_valid = 1'b1;
        s_data  = rnd();
        for (int c = 0; c < 2000 && lanes < 600; c++) begin
            if (m_valid && m_ready) begin
                if (lanes == 0) first = c;
                last = c;
                last_seq = m_seq;
                lanes++;
            end
            acc = s_valid && s_ready;
            tick();
            if (acc) begin
                sent++;
                if (sent == 300) s_valid = 1'b0;
                else s_data = rnd();
            end
        end
        s_valid = 1'b0;
        chk("stream_lane_count", v_t'(lanes), v_t'(600));
        chk("stream_one_per_cycle", v_t'(last - first), v_t'(599));
        chk("stream_last_seq_wrapped", v_t'(last_seq), v_t'(8'd43));
        tick();
        tick();

        // Clock enable freeze while in L0
        do_reset();
        m_ready = 1'b1;
        pd = rnd();
        s_data  = pd;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        chk("ce_l0_data", v_t'(m_data), v_t'(pd[2*LW-1:LW]));
        ap_ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ce_s_ready", v_t'(s_ready), v_t'(1'b0));
            chk("ce_hold_valid", v_t'(m_valid), v_t'(1'b1));
            chk("ce_hold_data", v_t'(m_data), v_t'(pd[2*LW-1:LW]));
            chk("ce_hold_lane", v_t'(m_lane), v_t'(1'b0));
        end
        ap_ce = 1'b1;
        tick();
        chk("ce_resume_data", v_t'(m_data), v_t'(pd[LW-1:0]));
        chk("ce_resume_lane", v_t'(m_lane), v_t'(1'b1));
        tick();
        chk("ce_resume_drain", v_t'(m_valid), v_t'(1'b0));

        // Reset while in L1 with one packet buffered
        do_reset();
        m_ready = 1'b1;
        p0 = rnd(); p1 = rnd(); p2 = rnd();
        s_valid = 1'b1;
        s_data  = p0;
        tick();
        s_data = p1;
        tick();
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        chk("rm_l1_lane", v_t'(m_lane), v_t'(1'b1));
        chk("rm_l1_data", v_t'(m_data), v_t'(p0[LW-1:0]));
        chk("rm_buffered", v_t'(s_ready), v_t'(1'b1));
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = p2;
        tick();
        s_valid = 1'b0;
        tick();
        chk("rm_new_l0_data", v_t'(m_data), v_t'(p2[2*LW-1:LW]));
        chk("rm_new_l0_seq", v_t'(m_seq), v_t'(8'd0));
        tick();
        chk("rm_new_l1_data", v_t'(m_data), v_t'(p2[LW-1:0]));
        tick();
        chk("rm_no_stale", v_t'(m_valid), v_t'(1'b0));

        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            ap_ce   = ($urandom_range(0, 9) != 0);
            s_valid = ($urandom_range(0, 2) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_data  = rnd();
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick();
        end
        ap_ce   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
